// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU issue stage: decode, operand select, registered output with skid buffer
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_l,
  input  logic            flush_w_i_h,
  input  logic            in_valid_w_i_h,
  output logic            in_ready_w_o_h,
  input  logic [6:0]      opcode_w_i,
  input  logic [2:0]      funct3_w_i,
  input  logic [6:0]      funct7_w_i,
  input  logic [XLEN-1:0] rs1_data_w_i,
  input  logic [XLEN-1:0] rs2_data_w_i,
  input  logic [XLEN-1:0] imm_w_i,
  input  logic [XLEN-1:0] pc_w_i,
  output logic            out_valid_w_o_h,
  input  logic            out_ready_w_i_h,
  output logic [XLEN-1:0] a_data_w_o,
  output logic [XLEN-1:0] b_data_w_o,
  output logic [3:0]      alu_control_w_o,
  output logic            illegal_w_o_h
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b1000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Payload layout: {illegal, ctrl[3:0], a[XLEN-1:0], b[XLEN-1:0]}
  localparam int PW = 2*XLEN + 5;

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic [PW-1:0]   dec_payload;

  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;

  logic            accept;
  logic            main_load;
  logic            is_shift_imm;
  logic            f3_add_or_sr;

  always_comb begin
    dec_a        = '0;
    dec_b        = '0;
    dec_ctrl     = ALU_ADD;
    dec_illegal  = 1'b0;
    is_shift_imm = (funct3_w_i == 3'b001) || (funct3_w_i == 3'b101);
    f3_add_or_sr = (funct3_w_i == 3'b000) || (funct3_w_i == 3'b101);

    case (opcode_w_i)
      OPC_OP: begin
        dec_a       = rs1_data_w_i;
        dec_b       = rs2_data_w_i;
        dec_ctrl    = {funct7_w_i[5] & f3_add_or_sr, funct3_w_i};
        dec_illegal = !((funct7_w_i == F7_ZERO) ||
                        ((funct7_w_i == F7_ALT) && f3_add_or_sr));
      end
      OPC_OP_IMM: begin
        dec_a       = rs1_data_w_i;
        dec_b       = is_shift_imm ? {{(XLEN-5){1'b0}}, imm_w_i[4:0]} : imm_w_i;
        // Only SRAI uses the alternate encoding; there is no SUBI.
        dec_ctrl    = {funct7_w_i[5] & (funct3_w_i == 3'b101), funct3_w_i};
        dec_illegal = ((funct3_w_i == 3'b001) && (funct7_w_i != F7_ZERO)) ||
                      ((funct3_w_i == 3'b101) && (funct7_w_i != F7_ZERO) &&
                       (funct7_w_i != F7_ALT));
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec_a = rs1_data_w_i;
        dec_b = imm_w_i;
      end
      OPC_LUI: begin
        dec_b = imm_w_i;
      end
      OPC_AUIPC: begin
        dec_a = pc_w_i;
        dec_b = imm_w_i;
      end
      OPC_JAL: begin
        dec_a = pc_w_i;
        dec_b = XLEN'(4);
      end
      OPC_BRANCH: begin
        dec_a = rs1_data_w_i;
        dec_b = rs2_data_w_i;
        case (funct3_w_i[2:1])
          2'b00:   dec_ctrl = ALU_SUB;
          2'b10:   dec_ctrl = ALU_SLT;
          2'b11:   dec_ctrl = ALU_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase

    // Undecodable ops still flow down the pipe, but with neutral operands.
    if (dec_illegal) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = ALU_ADD;
    end
  end

  assign dec_payload = {dec_illegal, dec_ctrl, dec_a, dec_b};

  // in_ready depends only on registered state, so out_ready never reaches it combinationally.
  assign in_ready_w_o_h = !skid_valid_q;
  assign accept         = in_valid_w_i_h & in_ready_w_o_h;
  assign main_load      = !out_valid_q | out_ready_w_i_h;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    if (flush_w_i_h) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no input competes here.
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          main_d = dec_payload;
        end
      end
    end else if (accept) begin
      skid_d       = dec_payload;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid_w_o_h = out_valid_q;
  assign illegal_w_o_h   = main_q[PW-1];
  assign alu_control_w_o = main_q[PW-2 -: 4];
  assign a_data_w_o      = main_q[2*XLEN-1 -: XLEN];
  assign b_data_w_o      = main_q[XLEN-1:0];

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1, rs2, imm, pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_data, b_data;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic        ill;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk_w_i         (clk),
    .rst_w_i_l       (rst_n),
    .flush_w_i_h     (flush),
    .in_valid_w_i_h  (in_valid),
    .in_ready_w_o_h  (in_ready),
    .opcode_w_i      (opcode),
    .funct3_w_i      (funct3),
    .funct7_w_i      (funct7),
    .rs1_data_w_i    (rs1),
    .rs2_data_w_i    (rs2),
    .imm_w_i         (imm),
    .pc_w_i          (pc),
    .out_valid_w_o_h (out_valid),
    .out_ready_w_i_h (out_ready),
    .a_data_w_o      (a_data),
    .b_data_w_o      (b_data),
    .alu_control_w_o (alu_ctrl),
    .illegal_w_o_h   (illegal)
  );

  function automatic exp_t legal_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ill  = 1'b0;
    e.ctrl = c;
    e.a    = a;
    e.b    = b;
    return e;
  endfunction

  // Instruction-level meaning of each op, written from the ISA rules.
  function automatic exp_t ref_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [31:0] im, input logic [31:0] p);
    exp_t e;
    int   br_code[8];
    bit   shift;
    br_code = '{8, 8, -1, -1, 2, 2, 3, 3};
    e       = '0;
    e.ill   = 1'b1;
    shift   = (f3 == 3'd1) || (f3 == 3'd5);
    case (op)
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
               e = legal_op({f7 == 7'h20, f3}, r1, r2);
      7'h13: if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)))
               e = legal_op({f3 == 3'd5 && f7 == 7'h20, f3}, r1, shift ? (im & 32'h1f) : im);
      7'h03, 7'h23, 7'h67: e = legal_op(4'd0, r1, im);
      7'h37: e = legal_op(4'd0, 32'd0, im);
      7'h17: e = legal_op(4'd0, p, im);
      7'h6F: e = legal_op(4'd0, p, 32'd4);
      7'h63: if (br_code[f3] >= 0) e = legal_op(4'(br_code[f3]), r1, r2);
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p, input logic v);
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    rs1      = r1;
    rs2      = r2;
    imm      = im;
    pc       = p;
    in_valid = v;
  endtask

  function automatic logic [68:0] obs_payload();
    return {illegal, alu_ctrl, a_data, b_data};
  endfunction

  initial begin
    int   sent;
    int   cycles;
    bit   pop, push;
    exp_t cand;
    logic [6:0] opcs[9];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63};

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", obs_payload(), 0);
    rst_n = 1'b1;

    // Directed decode checks with a free-flowing output.
    out_ready = 1'b1;
    drive(7'h33, 3'd0, 7'h20, 32'd5, 32'd3, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sub_valid", out_valid, 1);
    chk("sub_payload", obs_payload(), {1'b0, 4'b1000, 32'd5, 32'd3});
    drive(7'h13, 3'd5, 7'h20, 32'h9, 32'h0, 32'h407, 32'h0, 1'b1);
    @(negedge clk);
    chk("srai_payload", obs_payload(), {1'b0, 4'b1101, 32'h9, 32'h7});
    drive(7'h17, 3'd0, 7'h00, 32'h1, 32'h2, 32'h2000, 32'h100, 1'b1);
    @(negedge clk);
    chk("auipc_payload", obs_payload(), {1'b0, 4'b0000, 32'h100, 32'h2000});
    drive(7'h63, 3'd6, 7'h00, 32'h11, 32'h22, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("bltu_payload", obs_payload(), {1'b0, 4'b0011, 32'h11, 32'h22});
    drive(7'h00, 3'd0, 7'h00, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    @(negedge clk);
    chk("badopc_payload", obs_payload(), {1'b1, 4'b0000, 32'h0, 32'h0});
    chk("badopc_valid", out_valid, 1);
    drive(7'h63, 3'd2, 7'h00, 32'h11, 32'h22, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("badbr_payload", obs_payload(), {1'b1, 4'b0000, 32'h0, 32'h0});
    drive(7'h33, 3'd1, 7'h20, 32'h11, 32'h22, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("badsll_payload", obs_payload(), {1'b1, 4'b0000, 32'h0, 32'h0});
    drive(7'h6F, 3'd0, 7'h00, 32'h11, 32'h22, 32'h0, 32'h80, 1'b1);
    @(negedge clk);
    chk("jal_payload", obs_payload(), {1'b0, 4'b0000, 32'h80, 32'h4});
    drive(7'h37, 3'd0, 7'h00, 32'h11, 32'h22, 32'habcde000, 32'h80, 1'b1);
    @(negedge clk);
    chk("lui_payload", obs_payload(), {1'b0, 4'b0000, 32'h0, 32'habcde000});
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);

    // Backpressure: X held, Y in skid, Z refused.
    out_ready = 1'b0;
    drive(7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("bp_x_valid", out_valid, 1);
    chk("bp_x_ready", in_ready, 1);
    chk("bp_x_payload", obs_payload(), {1'b0, 4'b0000, 32'd1, 32'd2});
    drive(7'h33, 3'd7, 7'h00, 32'd3, 32'd4, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("bp_hold1_payload", obs_payload(), {1'b0, 4'b0000, 32'd1, 32'd2});
    chk("bp_full_ready", in_ready, 0);
    drive(7'h33, 3'd4, 7'h00, 32'd5, 32'd6, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("bp_hold2_payload", obs_payload(), {1'b0, 4'b0000, 32'd1, 32'd2});
    chk("bp_hold2_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_y_valid", out_valid, 1);
    chk("bp_y_payload", obs_payload(), {1'b0, 4'b0111, 32'd3, 32'd4});
    chk("bp_y_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_empty_valid", out_valid, 0);

    // Flush with both entries held and a same-cycle input.
    out_ready = 1'b0;
    drive(7'h33, 3'd0, 7'h00, 32'd7, 32'd8, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    drive(7'h33, 3'd0, 7'h00, 32'd9, 32'd10, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1;
    drive(7'h33, 3'd0, 7'h00, 32'd11, 32'd12, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_no_emit", out_valid, 0);

    // Asynchronous reset between edges while two ops are held.
    out_ready = 1'b0;
    drive(7'h33, 3'd0, 7'h00, 32'd13, 32'd14, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    drive(7'h33, 3'd0, 7'h00, 32'd15, 32'd16, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_payload", obs_payload(), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_post_valid", out_valid, 0);

    // Random stream against a FIFO model of at most two in-flight ops.
    q.delete();
    sent   = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 60000) begin
      chk("rnd_out_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) chk("rnd_payload", obs_payload(), q[0]);

      if ($urandom_range(0, 9) == 0) opcode = 7'($urandom);
      else opcode = opcs[$urandom_range(0, 8)];
      funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       funct7 = 7'h00;
        1:       funct7 = 7'h20;
        default: funct7 = 7'($urandom);
      endcase
      rs1       = $urandom;
      rs2       = $urandom;
      imm       = $urandom;
      pc        = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      cand      = ref_op(opcode, funct3, funct7, rs1, rs2, imm, pc);
      pop       = (q.size() > 0) && out_ready;
      push      = in_valid && (q.size() < 2);

      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(cand);
          sent++;
        end
      end
      @(negedge clk);
      cycles++;
    end
    chk("rnd_stream_done", sent, 10000);

    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("tail_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("tail_payload", obs_payload(), q[0]);
      @(posedge clk);
      if (q.size() > 0) void'(q.pop_front());
      @(negedge clk);
    end
    chk("tail_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
